// File: rtl/imem_instr_encoder.sv
// Packs RV32I field bundles (R/LOAD/STORE/BRANCH/OP-IMM) into instruction words,
// buffers them in a small FIFO and streams them into imem at consecutive word addresses.
module imem_instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cls,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              out_vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              legal_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              wr_done_s;
  logic              full_s;
  logic              in_ready_s;
  logic [31:0]       enc_s;

  // BRANCH carries imm[12:1] in imm, so every bit index below is one lower than the ISA's.
  function automatic logic [31:0] encode(
    input logic [2:0]  cls,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [31:0] word;
    word = 32'd0;
    case (cls)
      3'd0:    word = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      3'd1:    word = {imm, rs1, f3, rd, 7'b0000011};
      3'd2:    word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'd3:    word = {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], 7'b1100011};
      3'd4:    word = {imm, rs1, f3, rd, 7'b0010011};
      default: word = 32'd0;
    endcase
    return word;
  endfunction

  assign legal_s    = (in_cls <= 3'd4);
  assign full_s     = (count_q == FULL_CNT);
  assign in_ready_s = (state_q != ST_DRAIN) && (state_q != ST_DONE) && !full_s;
  assign accept_s   = in_valid && in_ready_s;
  assign push_s     = accept_s && legal_s;
  assign wr_done_s  = out_vld_q && imem_ready;
  // The output register refills from the FIFO whenever it is empty or finishing a write.
  assign pop_s      = (count_q != {CNT_W{1'b0}}) && (!out_vld_q || wr_done_s);
  assign enc_s      = encode(in_cls, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm);

  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= enc_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      out_vld_q <= 1'b0;
      addr_q    <= BASE_A;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        out_vld_q <= 1'b1;
        wdata_q   <= mem_q[rd_ptr_q];
      end else if (wr_done_s) begin
        out_vld_q <= 1'b0;
      end
      if (wr_done_s) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (accept_s && !legal_s) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q <= in_last ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_s && in_last) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((count_q == {CNT_W{1'b0}}) && !out_vld_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_s;
  assign imem_we    = out_vld_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_instr_encoder.sv
// Directed and randomized checks of imem_instr_encoder against a queue-based reference
// model; a second instance with a 2-bit address exercises address wrap and done.
module tb_imem_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid2;
  logic        in_ready, in_ready2;
  logic [2:0]  in_cls;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic        in_last;
  logic        imem_ready;
  logic        imem_we, imem_we2;
  logic [7:0]  imem_addr;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata, imem_wdata2;
  logic        done, done2, err, err2;

  int n_chk  = 0;
  int n_fail = 0;
  int n_push = 0;

  logic [31:0] exp_q0[$], exp_q1[$];
  logic [31:0] log_a0[$], log_d0[$], log_a1[$], log_d1[$];
  int          wr_cnt0, wr_cnt1;
  bit          drain0, drain1, err_m0, err_m1;

  always #5 clk = ~clk;

  imem_instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .done(done), .err(err)
  );

  imem_instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_cls(in_cls), .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we2), .imem_ready(imem_ready), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .done(done2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoder: builds the word from the ISA bit positions with plain arithmetic.
  function automatic logic [31:0] tb_enc(input int unsigned cls, f3, f7, rd, rs1, rs2, imm);
    int unsigned op, w, off;
    case (cls)
      0:       op = 'h33;
      1:       op = 'h03;
      2:       op = 'h23;
      3:       op = 'h63;
      default: op = 'h13;
    endcase
    w = op + (f3 << 12) + (rs1 << 15);
    if (cls == 0) begin
      w = w + (rd << 7) + (rs2 << 20) + (f7 << 30);
    end else if (cls == 2) begin
      w = w + ((imm % 32) << 7) + (rs2 << 20) + ((imm / 32) << 25);
    end else if (cls == 3) begin
      off = imm * 2;
      w = w + (((off / 2048) % 2) << 7) + (((off / 2) % 16) << 8) + (rs2 << 20)
            + (((off / 32) % 64) << 25) + (((off / 4096) % 2) << 31);
    end else begin
      w = w + (rd << 7) + (imm << 20);
    end
    return w;
  endfunction

  task automatic reset_model();
    exp_q0.delete(); exp_q1.delete();
    wr_cnt0 = 0; wr_cnt1 = 0;
    drain0 = 0; drain1 = 0; err_m0 = 0; err_m1 = 0;
  endtask

  // One clock: check outputs against the model, then update the model from the handshakes.
  task automatic tick();
    logic a0, a1, legal;
    logic [31:0] e;
    chk("in_ready", 32'(in_ready), 32'(!drain0 && exp_q0.size() < 5));
    chk("in_ready2", 32'(in_ready2), 32'(!drain1 && exp_q1.size() < 5));
    chk("err", 32'(err), 32'(err_m0));
    chk("err2", 32'(err2), 32'(err_m1));
    if (imem_we && imem_ready && !rst) begin
      chk("write_pending", 32'(exp_q0.size() != 0), 32'd1);
      if (exp_q0.size() != 0) begin
        chk("wdata", imem_wdata, exp_q0[0]);
        chk("waddr", 32'(imem_addr), 32'(wr_cnt0 % 256));
        void'(exp_q0.pop_front());
      end
      log_a0.push_back(32'(imem_addr)); log_d0.push_back(imem_wdata); wr_cnt0++;
    end
    if (imem_we2 && imem_ready && !rst) begin
      chk("write_pending2", 32'(exp_q1.size() != 0), 32'd1);
      if (exp_q1.size() != 0) begin
        chk("wdata2", imem_wdata2, exp_q1[0]);
        chk("waddr2", 32'(imem_addr2), 32'(wr_cnt1 % 4));
        void'(exp_q1.pop_front());
      end
      log_a1.push_back(32'(imem_addr2)); log_d1.push_back(imem_wdata2); wr_cnt1++;
    end
    a0 = in_valid && in_ready && !rst;
    a1 = in_valid2 && in_ready2 && !rst;
    legal = (in_cls <= 3'd4);
    e = tb_enc(in_cls, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm);
    @(posedge clk);
    if (rst) begin
      reset_model();
    end else begin
      if (a0) begin
        if (legal) begin exp_q0.push_back(e); n_push++; end else err_m0 = 1;
        if (in_last) drain0 = 1;
      end
      if (a1) begin
        if (legal) exp_q1.push_back(e); else err_m1 = 1;
        if (in_last) drain1 = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_fields(input int c, f3, f7, rd, rs1, rs2, imm);
    in_cls = 3'(c); in_funct3 = 3'(f3); in_f7b5 = 1'(f7);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 12'(imm);
  endtask

  task automatic rand_fields(input bit allow_illegal);
    int c;
    c = $urandom_range(0, 4);
    if (allow_illegal && ($urandom_range(0, 7) == 0)) c = $urandom_range(5, 7);
    set_fields(c, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 4095));
  endtask

  task automatic send(input int sel, input int c, f3, f7, rd, rs1, rs2, imm, input bit last);
    bit ok;
    ok = 0;
    set_fields(c, f3, f7, rd, rs1, rs2, imm);
    in_last = last;
    if (sel == 0) in_valid = 1'b1; else in_valid2 = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = (sel == 0) ? in_ready : in_ready2;
      tick();
    end
    in_valid = 1'b0; in_valid2 = 1'b0; in_last = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_rand(input int sel, input bit last);
    rand_fields(1'b0);
    send(sel, in_cls, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm, last);
  endtask

  task automatic drain();
    for (int n = 0; n < 80; n++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && !imem_we && !imem_we2) break;
      tick();
    end
    chk("drain_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic clear_logs();
    log_a0.delete(); log_d0.delete(); log_a1.delete(); log_d1.delete();
  endtask

  initial begin
    int acc;
    rst = 1'b1; in_valid = 0; in_valid2 = 0; in_last = 0; imem_ready = 0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();

    // T1 reset state
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    chk("t1_we", 32'(imem_we), 32'd0);
    chk("t1_addr", 32'(imem_addr), 32'd0);
    chk("t1_wdata", imem_wdata, 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_err", 32'(err), 32'd0);

    // T2 reference program
    imem_ready = 1'b1; clear_logs();
    send(0, 4, 0, 0, 1, 0, 0, 5, 0);
    send(0, 1, 2, 0, 2, 1, 0, 8, 0);
    send(0, 2, 2, 0, 0, 1, 2, 12, 0);
    send(0, 0, 0, 0, 3, 1, 2, 0, 0);
    send(0, 0, 0, 1, 3, 1, 2, 0, 0);
    send(0, 3, 0, 0, 0, 1, 2, 4, 0);
    drain();
    chk("t2_count", 32'(log_d0.size()), 32'd6);
    if (log_d0.size() == 6) begin
      chk("t2_addi", log_d0[0], 32'h00500093);
      chk("t2_lw", log_d0[1], 32'h0080A103);
      chk("t2_sw", log_d0[2], 32'h0020A623);
      chk("t2_add", log_d0[3], 32'h002081B3);
      chk("t2_sub", log_d0[4], 32'h402081B3);
      chk("t2_beq", log_d0[5], 32'h00208463);
      for (int k = 0; k < 6; k++) chk("t2_addr", log_a0[k], 32'(k));
    end

    // T3 stall capacity, then one write per cycle on release
    do_reset();
    imem_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int i = 0; i < 8; i++) begin
      rand_fields(1'b0);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_accepted", 32'(acc), 32'd5);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_hold_addr", 32'(imem_addr), 32'd0);
    if (exp_q0.size() != 0) chk("t3_hold_data", imem_wdata, exp_q0[0]);
    clear_logs(); imem_ready = 1'b1;
    repeat (5) tick();
    chk("t3_writes", 32'(log_a0.size()), 32'd5);
    for (int k = 0; k < log_a0.size(); k++) chk("t3_addr", log_a0[k], 32'(k));
    drain();

    // T4 illegal class between legal bundles
    do_reset(); clear_logs();
    send_rand(0, 0);
    send(0, 6, 1, 0, 4, 5, 6, 7, 0);
    send_rand(0, 0);
    drain();
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_writes", 32'(log_a0.size()), 32'd2);
    for (int k = 0; k < log_a0.size(); k++) chk("t4_addr", log_a0[k], 32'(k));

    // T5 2-bit address wrap and done on the last bundle
    do_reset(); clear_logs();
    for (int i = 0; i < 5; i++) send_rand(1, i == 4);
    chk("t5_done_early", 32'(done2), 32'd0);
    drain();
    for (int n = 0; n < 4 && !done2; n++) tick();
    chk("t5_done", 32'(done2), 32'd1);
    chk("t5_writes", 32'(log_a1.size()), 32'd5);
    if (log_a1.size() == 5) chk("t5_wrap_addr", log_a1[4], 32'd0);
    in_valid2 = 1'b1;
    repeat (3) tick();
    in_valid2 = 1'b0;
    chk("t5_in_ready", 32'(in_ready2), 32'd0);
    chk("t5_done_held", 32'(done2), 32'd1);
    chk("t5_no_more", 32'(log_a1.size()), 32'd5);

    // T6 reset discards buffered words
    do_reset();
    imem_ready = 1'b0;
    repeat (3) send_rand(0, 0);
    clear_logs();
    do_reset();
    chk("t6_we", 32'(imem_we), 32'd0);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_err", 32'(err), 32'd0);
    imem_ready = 1'b1;
    repeat (10) tick();
    chk("t6_no_writes", 32'(log_a0.size()), 32'd0);

    // Randomized traffic with random imem back-pressure
    do_reset(); clear_logs(); n_push = 0;
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      imem_ready = 1'($urandom_range(0, 1));
      rand_fields(1'b1);
      tick();
    end
    in_valid = 1'b0; imem_ready = 1'b1;
    drain();
    chk("rand_write_total", 32'(log_d0.size()), 32'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

endmodule
